// File: rtl/trivium_stream_xor_if.sv
// -----------------------------------------------------------------------------
// trivium_stream_xor_if
//
// Bundles the three streaming channels of trivium_stream_xor:
//   keystream in : ks_block, ks_len, ks_valid -> ks_ready
//   plaintext in : pt_data, pt_valid          -> pt_ready
//   cipher out   : ct_data, ct_valid, ct_last <- ct_ready
//   status       : done (one-cycle pulse when the final byte is taken)
//
// Modports:
//   slave  - the XOR block itself
//   master - the environment driving keystream/plaintext and sinking ciphertext
// -----------------------------------------------------------------------------
interface trivium_stream_xor_if #(
  parameter int KS_W  = 4096,
  parameter int LEN_W = 16
);
  localparam int DATA_W = 8;

  logic [KS_W-1:0]   ks_block;
  logic [LEN_W-1:0]  ks_len;
  logic              ks_valid;
  logic              ks_ready;

  logic [DATA_W-1:0] pt_data;
  logic              pt_valid;
  logic              pt_ready;

  logic [DATA_W-1:0] ct_data;
  logic              ct_valid;
  logic              ct_ready;
  logic              ct_last;

  logic              done;

  modport slave (
    input  ks_block, ks_len, ks_valid,
    input  pt_data, pt_valid,
    input  ct_ready,
    output ks_ready, pt_ready,
    output ct_data, ct_valid, ct_last,
    output done
  );

  modport master (
    output ks_block, ks_len, ks_valid,
    output pt_data, pt_valid,
    output ct_ready,
    input  ks_ready, pt_ready,
    input  ct_data, ct_valid, ct_last,
    input  done
  );
endinterface

// File: rtl/trivium_stream_xor.sv
// -----------------------------------------------------------------------------
// trivium_stream_xor
//
// Captures one finished Trivium keystream block (up to KS_W bits) with its
// bit length, then XORs it byte by byte (MSB-first) into a plaintext byte
// stream, emitting ciphertext over a registered valid/ready output.
// Encryption and decryption are the same operation.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-high; returns the block to IDLE at once
//   bus    - trivium_stream_xor_if.slave (keystream, plaintext, ciphertext,
//            done pulse)
//
// Byte count is min(ks_len, KS_W) >> 3; trailing partial bytes are dropped.
// -----------------------------------------------------------------------------
module trivium_stream_xor #(
  parameter int KS_W  = 4096,
  parameter int LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  trivium_stream_xor_if.slave   bus
);

  localparam int DATA_W = 8;
  localparam int NB_MAX = KS_W / 8;
  localparam int IDX_W  = $clog2(NB_MAX) + 1;
  localparam int SEL_W  = $clog2(KS_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [KS_W-1:0]   ks_reg;
  logic [IDX_W-1:0]  nbytes;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nbytes_in;
  logic [SEL_W-1:0]  ks_base;
  logic [DATA_W-1:0] ks_byte;

  logic [DATA_W-1:0] ct_data_q;
  logic              ct_valid_q;
  logic              ct_last_q;
  logic              done_q;

  logic              pt_fire;
  logic              ct_fire;
  logic              last_byte;

  // Clamp the requested length to the block width before converting to bytes;
  // the compare is done at 32 bits so an oversize ks_len cannot alias.
  assign nbytes_in = (32'(bus.ks_len) > 32'(KS_W)) ? IDX_W'(NB_MAX)
                                                    : IDX_W'(32'(bus.ks_len) >> 3);

  // Byte k sits at the top of the block going down: bits [KS_W-1-8k -: 8].
  assign ks_base   = SEL_W'(KS_W - 8 - 8 * int'(idx));
  assign ks_byte   = ks_reg[ks_base +: DATA_W];

  assign last_byte = (idx == nbytes - IDX_W'(1));

  assign bus.ks_ready = (state == IDLE);
  assign bus.pt_ready = (state == RUN) && (!ct_valid_q || bus.ct_ready);
  assign bus.ct_data  = ct_data_q;
  assign bus.ct_valid = ct_valid_q;
  assign bus.ct_last  = ct_last_q;
  assign bus.done     = done_q;

  assign pt_fire = bus.pt_valid && bus.pt_ready;
  assign ct_fire = ct_valid_q && bus.ct_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always updated with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment up front keeps this block purely
    // combinational; without it an unhandled path would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.ks_valid && (nbytes_in != '0)) state_nxt = RUN;
      RUN:     if (pt_fire && last_byte)              state_nxt = DRAIN;
      DRAIN:   if (ct_fire)                           state_nxt = IDLE;
      default:                                        state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Keystream storage
  // ---------------------------------------------------------------------------
  // NOTE: this wide register is deliberately left out of reset; it is always
  // rewritten at capture before any byte is read from it, and resetting it
  // would only add reset fan-out.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && bus.ks_valid) begin
      ks_reg <= bus.ks_block;
    end
  end

  // ---------------------------------------------------------------------------
  // Index, byte count and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nbytes     <= '0;
      idx        <= '0;
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
      ct_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.ks_valid) begin
            nbytes <= nbytes_in;
            idx    <= '0;
            // An empty block completes immediately.
            done_q <= (nbytes_in == '0);
          end
        end
        RUN: begin
          // A new accept overwrites the output register in the same cycle the
          // old byte leaves, so full throughput needs no bubble.
          if (pt_fire) begin
            ct_data_q  <= bus.pt_data ^ ks_byte;
            ct_valid_q <= 1'b1;
            ct_last_q  <= last_byte;
            idx        <= idx + IDX_W'(1);
          end else if (ct_fire) begin
            ct_valid_q <= 1'b0;
            ct_last_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (ct_fire) begin
            ct_valid_q <= 1'b0;
            ct_last_q  <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_stream_xor.sv
// -----------------------------------------------------------------------------
// tb_trivium_stream_xor
//
// Self-checking bench for trivium_stream_xor. A negedge monitor logs every
// accepted plaintext byte, ciphertext byte and done pulse with a cycle stamp;
// expected ciphertext comes from a shift-based reference of the keystream
// byte order and the clamped byte count.
// -----------------------------------------------------------------------------
module tb_trivium_stream_xor;

  localparam int KS_W  = 4096;
  localparam int LEN_W = 16;

  typedef struct {
    logic       last;
    logic [7:0] data;
    int         cyc;
  } ct_rec_t;

  typedef struct {
    int len;
    int exp_n;
    int bp;     // 0: ct_ready always 1, 1: random ct_ready, 2: 5-cycle stall
    int busy;   // inject a second ks_valid while running
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  trivium_stream_xor_if #(.KS_W(KS_W), .LEN_W(LEN_W)) bus ();

  trivium_stream_xor #(.KS_W(KS_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_err    = 0;
  int         n_checks = 0;
  int         cyc      = 0;
  int         pt_cnt   = 0;
  int         cap_cyc  = -1;
  int         pt_cyc_q[$];
  int         done_q[$];
  ct_rec_t    ct_q[$];
  logic [7:0] pt_q[$];

  always @(posedge clk) cyc++;

  // Monitor: handshakes sampled half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ks_valid && bus.ks_ready) cap_cyc = cyc;
      if (bus.pt_valid && bus.pt_ready) begin
        pt_cnt++;
        pt_cyc_q.push_back(cyc);
      end
      if (bus.ct_valid && bus.ct_ready) ct_q.push_back('{bus.ct_last, bus.ct_data, cyc});
      if (bus.done) done_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int model_n(input int len);
    return ((len > KS_W) ? KS_W : len) / 8;
  endfunction

  function automatic logic [7:0] model_ks(input logic [KS_W-1:0] blk, input int k);
    logic [KS_W-1:0] t;
    t = blk << (8 * k);
    return t[KS_W-1 -: 8];
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block(output logic [KS_W-1:0] b);
    for (int i = 0; i < KS_W / 32; i++) b[32*i +: 32] = $urandom;
  endtask

  task automatic fill_pt(input int n);
    pt_q.delete();
    for (int i = 0; i < n; i++) pt_q.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs();
    check("rst_ct_data",  bus.ct_data,  8'h00);
    check("rst_ct_valid", bus.ct_valid, 1'b0);
    check("rst_ct_last",  bus.ct_last,  1'b0);
    check("rst_done",     bus.done,     1'b0);
    check("rst_pt_ready", bus.pt_ready, 1'b0);
    check("rst_ks_ready", bus.ks_ready, 1'b1);
  endtask

  // Captures blk/len, streams pt_q through, then checks the logged result.
  // stop_at >= 0 abandons the block after that many plaintext bytes.
  task automatic run_block(input logic [KS_W-1:0] blk, input int len, input int exp_n,
                           input int bp, input int busy, input int stop_at);
    int         pt_b, ct_b, dn_b, r, budget, sent;
    logic       rdy, prev_valid, prev_last;
    logic [7:0] prev_data;

    pt_b = pt_cnt;
    ct_b = ct_q.size();
    dn_b = done_q.size();

    check("ks_ready_idle", bus.ks_ready, 1'b1);
    bus.ks_block = blk;
    bus.ks_len   = LEN_W'(len);
    bus.ks_valid = 1'b1;
    bus.pt_valid = 1'b0;
    bus.ct_ready = 1'b1;
    step();
    bus.ks_valid = 1'b0;
    check("ks_ready_cap", bus.ks_ready, exp_n == 0);
    check("pt_ready_cap", bus.pt_ready, exp_n != 0);

    r      = 0;
    budget = 6 * exp_n + 50;
    while (!bus.done && budget > 0 && !(stop_at >= 0 && pt_cnt - pt_b >= stop_at)) begin
      sent         = pt_cnt - pt_b;
      bus.pt_valid = (sent < pt_q.size());
      bus.pt_data  = (sent < pt_q.size()) ? pt_q[sent] : 8'h00;
      rdy          = (bp == 1) ? 1'($urandom_range(0, 1)) :
                     (bp == 2) ? !(r >= 4 && r < 9) : 1'b1;
      bus.ct_ready = rdy;
      if (busy != 0 && r == 2) begin
        bus.ks_block = ~blk;
        bus.ks_len   = 16'd64;
        bus.ks_valid = 1'b1;
      end else begin
        bus.ks_valid = 1'b0;
      end
      prev_data  = bus.ct_data;
      prev_valid = bus.ct_valid;
      prev_last  = bus.ct_last;
      step();
      r++;
      budget--;
      if (pt_cnt - pt_b > sent) begin
        check("lat_valid", bus.ct_valid, 1'b1);
        check("lat_data",  bus.ct_data,  pt_q[sent] ^ model_ks(blk, sent));
      end
      if (!rdy && prev_valid) begin
        check("hold_data",     bus.ct_data,  prev_data);
        check("hold_last",     bus.ct_last,  prev_last);
        check("hold_valid",    bus.ct_valid, 1'b1);
        check("hold_pt_ready", bus.pt_ready, 1'b0);
      end
    end
    bus.pt_valid = 1'b0;
    bus.ks_valid = 1'b0;
    bus.ct_ready = 1'b1;
    if (stop_at >= 0) return;

    check("done_seen", bus.done, 1'b1);
    step();
    step();
    check("done_pulses",  done_q.size() - dn_b, 1);
    check("ks_ready_end", bus.ks_ready, 1'b1);
    check("pt_consumed",  pt_cnt - pt_b, exp_n);
    check("ct_count",     ct_q.size() - ct_b, exp_n);
    for (int k = 0; k < exp_n && ct_b + k < ct_q.size(); k++) begin
      check("ct_byte", ct_q[ct_b+k].data, pt_q[k] ^ model_ks(blk, k));
      check("ct_last", ct_q[ct_b+k].last, k == exp_n - 1);
    end
    if (done_q.size() > dn_b) begin
      if (exp_n == 0)
        check("done_timing_empty", done_q[dn_b], cap_cyc + 1);
      else if (ct_q.size() > ct_b)
        check("done_timing", done_q[dn_b], ct_q[ct_q.size()-1].cyc + 1);
    end
    if (exp_n > 0 && pt_cnt - pt_b >= exp_n) begin
      check("first_pt_cycle", pt_cyc_q[pt_b], cap_cyc + 1);
      if (bp == 0)
        check("throughput", pt_cyc_q[pt_b+exp_n-1] - pt_cyc_q[pt_b], exp_n - 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t            vecs[10];
  logic [KS_W-1:0] blk;
  int              ct_b0;
  int              len;

  initial begin
    bus.ks_block = '0;
    bus.ks_len   = '0;
    bus.ks_valid = 1'b0;
    bus.pt_data  = '0;
    bus.pt_valid = 1'b0;
    bus.ct_ready = 1'b1;

    #2;
    check_reset_outputs();
    #10;
    reset = 1'b0;
    step();
    check_reset_outputs();

    // Zero keystream: ciphertext equals plaintext, full-rate streaming.
    pt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    ct_b0 = ct_q.size();
    run_block('0, 32, 4, 0, 0, -1);
    if (ct_q.size() >= ct_b0 + 4) begin
      check("zero_ks_b0", ct_q[ct_b0].data,   8'h11);
      check("zero_ks_b3", ct_q[ct_b0+3].data, 8'h44);
    end

    // Pattern keystream, 20 bits -> 2 bytes; third plaintext byte stays unused.
    blk = '0;
    blk[KS_W-1 -: 24] = 24'hA55AFF;
    pt_q = '{8'h00, 8'h00, 8'h00};
    ct_b0 = ct_q.size();
    run_block(blk, 20, 2, 0, 0, -1);
    if (ct_q.size() >= ct_b0 + 2) begin
      check("pattern_b0",   ct_q[ct_b0].data,   8'hA5);
      check("pattern_b1",   ct_q[ct_b0+1].data, 8'h5A);
      check("pattern_last", ct_q[ct_b0+1].last, 1'b1);
    end

    // Backpressure: five-cycle stall mid-block.
    rand_block(blk);
    fill_pt(10);
    run_block(blk, 80, 10, 2, 0, -1);

    // ks_valid while busy must not disturb the running block.
    rand_block(blk);
    fill_pt(8);
    run_block(blk, 64, 8, 0, 1, -1);

    // Reset mid-operation after three bytes, then a fresh block from byte 0.
    rand_block(blk);
    fill_pt(10);
    run_block(blk, 80, 10, 0, 0, 3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    #2;
    reset = 1'b0;
    step();
    rand_block(blk);
    fill_pt(6);
    run_block(blk, 48, 6, 1, 0, -1);

    // Table of lengths including clamp and empty cases.
    vecs = '{'{64,    8,   1, 0},
             '{15,    1,   1, 0},
             '{8,     1,   0, 0},
             '{4096,  512, 1, 0},
             '{4100,  512, 0, 0},
             '{7,     0,   0, 0},
             '{0,     0,   0, 0},
             '{65535, 512, 0, 0},
             '{123,   15,  2, 0},
             '{100,   12,  1, 1}};
    for (int v = 0; v < 10; v++) begin
      rand_block(blk);
      fill_pt(vecs[v].exp_n + int'($urandom_range(0, 2)));
      run_block(blk, vecs[v].len, vecs[v].exp_n, vecs[v].bp, vecs[v].busy, -1);
    end

    // Randomised blocks against the reference byte count.
    for (int t = 0; t < 8; t++) begin
      rand_block(blk);
      len = int'($urandom_range(0, 700));
      fill_pt(model_n(len) + int'($urandom_range(0, 2)));
      run_block(blk, len, model_n(len), 1, int'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trivium_stream_xor.md
# trivium_stream_xor

Downstream consumer of the ENCRIPT Trivium keystream generator. It captures one finished keystream block (up to 4096 bits) together with its bit length. It then XORs that keystream byte-by-byte into a plaintext byte stream and emits ciphertext bytes over valid/ready handshakes. Decryption uses the same path, since XOR is symmetric.

## Interface
- KS_W, 4096, keystream block width in bits; must be a multiple of 8.
- LEN_W, 16, width of the keystream length field.
- DATA_W, 8, byte width; fixed at 8.

- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ks_block  input  KS_W  keystream from ENCRIPT OUT.
- ks_len  input  LEN_W  valid keystream length in bits, same value given to ENCRIPT len.
- ks_valid  input  1  keystream block and length valid.
- ks_ready  output  1  block can accept a keystream; high only in IDLE.
- pt_data  input  8  plaintext byte.
- pt_valid  input  1  plaintext byte valid.
- pt_ready  output  1  plaintext byte accepted this cycle if pt_valid is also high.
- ct_data  output  8  ciphertext byte, registered.
- ct_valid  output  1  ciphertext byte valid.
- ct_ready  input  1  downstream accepts the ciphertext byte.
- ct_last  output  1  marks the final byte of the block.
- done  output  1  one-cycle pulse when the final byte is consumed downstream.

## Operation
- **Byte count:** nbytes = min(ks_len, KS_W) >> 3.
  - Trailing len bits that do not fill a whole byte are discarded.
  - ks_len > KS_W clamps to KS_W/8 = 512 bytes.
- **Byte ordering:** byte k uses ks_block[KS_W-1-8k -: 8], taken MSB-first. Byte 0 is ks_block[4095:4088].
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - ks_ready=1, pt_ready=0.
  - On ks_valid, capture ks_block into an internal register, latch nbytes, and clear the index idx to 0.
  - If nbytes=0, stay in IDLE and pulse done the next cycle. Otherwise go to RUN.
- **RUN:**
  - pt_ready = (!ct_valid || ct_ready).
  - On pt_valid&&pt_ready:
    - ct_data <= pt_data ^ ksbyte[idx].
    - ct_valid <= 1.
    - ct_last <= (idx == nbytes-1).
    - idx <= idx+1.
  - When the accepted byte has idx == nbytes-1, go to DRAIN.
  - If ct_valid&&ct_ready and no new byte is accepted in that cycle, ct_valid <= 0.
- **DRAIN:**
  - pt_ready=0.
  - On ct_valid&&ct_ready, clear ct_valid and ct_last, pulse done, and go to IDLE.
- **Ignored inputs:** ks_valid outside IDLE is ignored. The captured keystream stays unchanged until the next capture in IDLE.
- **Index width:** idx is clog2(KS_W/8)+1 bits. idx never exceeds nbytes, so there is no wrap-around.

## Timing
- **Reset values:**
  - ct_data=0, ct_valid=0, ct_last=0, done=0, pt_ready=0.
  - ks_ready=1, since the state resets to IDLE.
  - idx=0 and nbytes=0. The keystream register need not be cleared.
- **Reset mid-operation:** asserting reset in RUN or DRAIN discards the in-flight byte and the remainder of the block. The FSM returns to IDLE asynchronously.
- **Capture:** ks_valid sampled at edge N puts the FSM in RUN at N+1. The first pt_ready is high in the cycle following N.
- **Latency:** one cycle, from pt accept at edge M to ct_valid high after edge M.
- **Throughput:** one byte per cycle while ct_ready=1. Simultaneous ct accept and pt accept in the same cycle replaces the output register without a bubble.
- **Backpressure:** with ct_ready=0 and ct_valid=1, pt_ready=0. ct_data, ct_last and ct_valid hold stable until accepted.
- **done timing:** done is asserted for exactly one cycle after the edge where the last ct byte is accepted. For nbytes=0, done is asserted for one cycle after the capture edge.

## Test plan
- **Zero keystream:** ks_block=0, ks_len=32, pt bytes 11,22,33,44 with ct_ready=1.
  - ct = 11,22,33,44; ct_last on the 4th byte; done one cycle later; 4 cycles of throughput.
- **Pattern keystream:** ks_block top bytes A5,5A,FF, ks_len=20, pt=00,00,00.
  - nbytes=2, so ct = A5,5A with ct_last on 5A.
  - pt_ready=0 after the second byte; the third pt byte is not consumed.
- **Backpressure:** ct_ready held low 5 cycles mid-block.
  - ct_data stable, pt_ready=0, no byte lost or duplicated. The sequence matches the XOR reference.
- **Clamp and empty blocks:**
  - ks_len=4100 produces exactly 512 bytes, with ct_last on byte 511.
  - ks_len=7 produces no ct bytes, done one cycle after capture, FSM back in IDLE.
- **Reset mid-operation:** assert reset after byte 3 of 10.
  - All outputs return to their reset values immediately and ks_ready=1.
  - A new block then restarts from byte 0.
- **ks_valid while busy:** a second ks_valid with a different block during RUN is ignored.
  - Output still uses the first keystream.
